secded_decoder_pipe: RTL and testbench
======================================

// Module: secded_decoder_pipe
// PURPOSE
//  Parametrised, pipelined Hamming SECDED decoder with valid/ready handshakes on both sides.
//  - Generalises the fixed 8-bit decoder to any DATA_W.
//  - Keeps saturating corrected/uncorrectable event counters for status reporting.
//  - Sits between the memory/link read path and the consumer of corrected data.
// PARAMETERS
//  DATA_W  8   data bits per word; PAR_W = smallest p with 2^p >= DATA_W+p+1 (localparam, 4 @ 8)
//  CNT_W   16  width of each saturating error counter
//  CODE_W  --  localparam = DATA_W+PAR_W+1 (13 @ DATA_W=8)
// PORTS
//  clk          in   1       single clock, rising edge
//  rst_n        in   1       asynchronous, active-low reset
//  in_valid     in   1       codeword present on in_code
//  in_ready     out  1       decoder accepts in_code this cycle
//  in_code      in   CODE_W  [CODE_W-1]=overall (word) parity; idx i = Hamming position i+1
//  out_valid    out  1       decoded result present
//  out_ready    in   1       consumer accepts result
//  out_data     out  DATA_W  corrected data (raw data bits when uncorrectable)
//  out_syndrome out  PAR_W   Hamming syndrome
//  out_err_type out  2       00 none, 01 word-parity-bit only, 10 single corrected, 11 uncorrectable
//  cnt_clr      in   1       synchronous clear of both counters
//  cnt_corr     out  CNT_W   count of err_type 01/10 results
//  cnt_uncorr   out  CNT_W   count of err_type 11 results
// BEHAVIOUR
//  - Layout: parity bits at power-of-two positions; data bits fill remaining positions, ascending
//    (d0 at position 3). Overall parity is even across all CODE_W bits.
//  - Stage 1: register in_code, syndrome and overall-parity check on each accept.
//  - Stage 2: register corrected data and err_type. Latency 2 cycles, accept to out_valid.
//    Throughput 1 word/clk when out_ready stays high.
//  - Classification:
//    - syn==0, parity ok -> 00.
//    - syn==0, parity bad -> 01; data unchanged.
//    - syn!=0, parity bad, syn<=CODE_W-1 -> 10; flip position syn.
//    - syn!=0, parity bad, syn>CODE_W-1 -> 11.
//    - syn!=0, parity ok -> 11.
//  - Handshake:
//    - Transfer when valid&&ready.
//    - Stage k advances when its successor is empty or advancing.
//    - in_ready = !s1_valid || s1_adv; this is combinational from out_ready (no skid).
//    - out_* held stable while out_valid && !out_ready.
//  - Counters:
//    - Increment by 1 on each output transfer of the matching type, not on acceptance.
//    - Saturate at 2^CNT_W-1.
//    - cnt_clr wins over a same-cycle increment.
//  - Reset:
//    - All valids=0; out_data, out_syndrome, out_err_type = 0; counters = 0.
//    - Reset mid-operation discards in-flight words, with no partial output.
// CONFIGURATION
//  - SECDED_ERR_INJECT_EN defined:
//    - Adds input inj_mask [CODE_W-1:0].
//    - inj_mask is XORed into in_code at acceptance, before the syndrome is computed.
//  - SECDED_ERR_INJECT_EN undefined:
//    - Port absent; in_code is used unmodified. Function is otherwise identical.
// TESTING  (DATA_W=8; 0xA5 encodes to 0x0A27)
//  - 0x0A27, out_ready=1 -> 2 clk later out_data=0xA5, syn=0, type=00; counters unchanged.
//  - 0x0A07 (pos 6 flipped) -> data=0xA5, syn=6, type=10, cnt_corr=1.
//  - 0x1A27 (parity bit flipped) -> data=0xA5, syn=0, type=01.
//  - 0x0A06 -> syn=7, type=11, data=0xA1 (raw), cnt_uncorr=1.
//  - 0x0AAE (3 flips) -> syn=13 > 12 -> type=11.
//  - Stream 4 words, out_ready=0 for 3 clk:
//    - in_ready drops after 2 accepts; out_* stay stable.
//    - All 4 words emerge in order; no loss or duplication.
//  - Counter saturation and clear:
//    - CNT_W=2: 5 single errors -> cnt_corr=3.
//    - cnt_clr with a same-cycle error -> 0.
//  - Reset mid-operation:
//    - rst_n low with 2 words in flight -> out_valid=0 at once; no output after release.

Source files
------------

// File: rtl/secded_decoder_pipe.sv
// Two-stage pipelined Hamming SECDED decoder with valid/ready handshakes and saturating error counters.
// Optional build macro SECDED_ERR_INJECT_EN adds inj_mask, XORed into in_code on acceptance.
module secded_decoder_pipe #(
    parameter  int DATA_W = 8,
    parameter  int CNT_W  = 16,
    // Least p with 2^p >= DATA_W+p+1, found by iterating p = clog2(DATA_W+p+1) upward from a lower bound
    localparam int PAR_W0 = $clog2(DATA_W + 1),
    localparam int PAR_W1 = $clog2(DATA_W + PAR_W0 + 1),
    localparam int PAR_W2 = $clog2(DATA_W + PAR_W1 + 1),
    localparam int PAR_W  = $clog2(DATA_W + PAR_W2 + 1),
    localparam int CODE_W = DATA_W + PAR_W + 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CODE_W-1:0] in_code,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [PAR_W-1:0]  out_syndrome,
    output logic [1:0]        out_err_type,
    input  logic              cnt_clr,
`ifdef SECDED_ERR_INJECT_EN
    input  logic [CODE_W-1:0] inj_mask,
`endif
    output logic [CNT_W-1:0]  cnt_corr,
    output logic [CNT_W-1:0]  cnt_uncorr
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    // Hamming position of the k-th data bit: the k-th non-power-of-two position from 3 upward
    function automatic int data_pos(input int k);
        int n;
        int pos;
        n   = 0;
        pos = 0;
        for (int q = 3; q < CODE_W; q++) begin
            if ((q & (q - 1)) != 0) begin
                if (n == k) pos = q;
                n++;
            end
        end
        return pos;
    endfunction

    logic [CODE_W-1:0] code_in;
    logic [PAR_W-1:0]  syn_c;
    logic              par_bad_c;

    logic              s1_valid;
    logic [CODE_W-2:0] s1_code;
    logic [PAR_W-1:0]  s1_syn;
    logic              s1_par_bad;

    logic              s1_adv;
    logic              in_fire;
    logic              out_fire;

    logic [CODE_W-2:0] fixed_c;
    logic [DATA_W-1:0] data_c;
    logic [1:0]        err_c;

`ifdef SECDED_ERR_INJECT_EN
    assign code_in = in_code ^ inj_mask;
`else
    assign code_in = in_code;
`endif

    assign s1_adv   = s1_valid && (!out_valid || out_ready);
    assign in_ready = !s1_valid || s1_adv;
    assign in_fire  = in_valid && in_ready;
    assign out_fire = out_valid && out_ready;

    always_comb begin
        syn_c = '0;
        for (int p = 1; p < CODE_W; p++) begin
            if (code_in[p-1]) syn_c = syn_c ^ PAR_W'(p);
        end
        par_bad_c = ^code_in;
    end

    // Classify, then flip the addressed position only for a genuine single-bit error
    always_comb begin
        fixed_c = s1_code;
        err_c   = 2'b11;
        data_c  = '0;
        if (s1_syn == '0) begin
            err_c = s1_par_bad ? 2'b01 : 2'b00;
        end else if (s1_par_bad && int'(s1_syn) <= CODE_W - 1) begin
            err_c = 2'b10;
            for (int p = 1; p < CODE_W; p++) begin
                if (PAR_W'(p) == s1_syn) fixed_c[p-1] = ~s1_code[p-1];
            end
        end
        for (int k = 0; k < DATA_W; k++) begin
            data_c[k] = fixed_c[data_pos(k) - 1];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid   <= 1'b0;
            s1_code    <= '0;
            s1_syn     <= '0;
            s1_par_bad <= 1'b0;
        end else if (in_fire) begin
            s1_valid   <= 1'b1;
            s1_code    <= code_in[CODE_W-2:0];
            s1_syn     <= syn_c;
            s1_par_bad <= par_bad_c;
        end else if (s1_adv) begin
            s1_valid   <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid    <= 1'b0;
            out_data     <= '0;
            out_syndrome <= '0;
            out_err_type <= 2'b00;
        end else if (s1_adv) begin
            out_valid    <= 1'b1;
            out_data     <= data_c;
            out_syndrome <= s1_syn;
            out_err_type <= err_c;
        end else if (out_ready) begin
            out_valid    <= 1'b0;
        end
    end

    // Counters track delivered results, so a stalled word is counted once, when it leaves
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_corr   <= '0;
            cnt_uncorr <= '0;
        end else if (cnt_clr) begin
            cnt_corr   <= '0;
            cnt_uncorr <= '0;
        end else if (out_fire) begin
            if ((out_err_type == 2'b01 || out_err_type == 2'b10) && cnt_corr != CNT_MAX)
                cnt_corr <= cnt_corr + 1'b1;
            if (out_err_type == 2'b11 && cnt_uncorr != CNT_MAX)
                cnt_uncorr <= cnt_uncorr + 1'b1;
        end
    end

endmodule

// File: tb/tb_secded_decoder_pipe.sv
// Directed scoreboard bench for secded_decoder_pipe at DATA_W=8, CNT_W=2.
// Expected results are pushed on acceptance and popped when each result transfers out.
module tb_secded_decoder_pipe;

    localparam int DATA_W = 8;
    localparam int CNT_W  = 2;
    localparam int PAR_W  = 4;
    localparam int CODE_W = 13;

    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic [PAR_W-1:0]  syn;
        logic [1:0]        et;
    } exp_t;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              in_valid;
    logic              in_ready;
    logic [CODE_W-1:0] in_code;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic [PAR_W-1:0]  out_syndrome;
    logic [1:0]        out_err_type;
    logic              cnt_clr;
    logic [CNT_W-1:0]  cnt_corr;
    logic [CNT_W-1:0]  cnt_uncorr;
`ifdef SECDED_ERR_INJECT_EN
    logic [CODE_W-1:0] inj_mask = '0;
`endif

    int   errors = 0;
    int   checks = 0;
    exp_t sb[$];
    exp_t pend;
    exp_t front;
    int   exp_corr = 0;
    int   exp_uncorr = 0;

    always #5 clk = ~clk;

    secded_decoder_pipe #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_code      (in_code),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_data     (out_data),
        .out_syndrome (out_syndrome),
        .out_err_type (out_err_type),
        .cnt_clr      (cnt_clr),
`ifdef SECDED_ERR_INJECT_EN
        .inj_mask     (inj_mask),
`endif
        .cnt_corr     (cnt_corr),
        .cnt_uncorr   (cnt_uncorr)
    );

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Reference encoder: data into non-power-of-two positions, parity bits fix the syndrome to zero
    function automatic logic [CODE_W-1:0] encode(input logic [DATA_W-1:0] d);
        logic [CODE_W-1:0] c;
        logic [PAR_W-1:0]  s;
        int j;
        c = '0;
        s = '0;
        j = 0;
        for (int p = 1; p < CODE_W; p++) begin
            if ((p & (p - 1)) != 0) begin
                c[p-1] = d[j];
                j++;
            end
        end
        for (int p = 1; p < CODE_W; p++) if (c[p-1]) s = s ^ 4'(p);
        for (int k = 0; k < PAR_W; k++) c[(1 << k) - 1] = s[k];
        c[CODE_W-1] = ^c[CODE_W-2:0];
        return c;
    endfunction

    function automatic logic [CODE_W-1:0] flip(input logic [CODE_W-1:0] c, input int pos);
        logic [CODE_W-1:0] r;
        r = c;
        r[pos-1] = ~r[pos-1];
        return r;
    endfunction

    // Monitor: counter model, stall stability, in-order scoreboard compare, push on acceptance
    always @(negedge clk) begin
        if (!rst_n) begin
            sb.delete();
            exp_corr = 0;
            exp_uncorr = 0;
        end else begin
            checkOutput("cnt_corr_model", 32'(cnt_corr), exp_corr);
            checkOutput("cnt_uncorr_model", 32'(cnt_uncorr), exp_uncorr);
            if (out_valid && !out_ready && sb.size() > 0) begin
                checkOutput("hold_data", 32'(out_data), 32'(sb[0].data));
                checkOutput("hold_type", 32'(out_err_type), 32'(sb[0].et));
            end
            if (out_valid && out_ready) begin
                checkOutput("sb_nonempty", 32'(sb.size() != 0), 1);
                if (sb.size() != 0) begin
                    front = sb.pop_front();
                    checkOutput("out_data", 32'(out_data), 32'(front.data));
                    checkOutput("out_syndrome", 32'(out_syndrome), 32'(front.syn));
                    checkOutput("out_err_type", 32'(out_err_type), 32'(front.et));
                    if (!cnt_clr && (front.et == 2'b01 || front.et == 2'b10) && exp_corr < 3) exp_corr++;
                    if (!cnt_clr && front.et == 2'b11 && exp_uncorr < 3) exp_uncorr++;
                end
            end
            if (cnt_clr) begin
                exp_corr = 0;
                exp_uncorr = 0;
            end
            if (in_valid && in_ready) sb.push_back(pend);
        end
    end

    task automatic applyStimulus(input logic [CODE_W-1:0] code, input logic [7:0] d,
                                 input logic [3:0] s, input logic [1:0] t);
        bit ok;
        ok = 1'b0;
        pend = '{data: d, syn: s, et: t};
        in_code = code;
        in_valid = 1'b1;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (in_ready) begin
                ok = 1'b1;
                break;
            end
        end
        @(posedge clk);
        #1 in_valid = 1'b0;
        checkOutput("accept_timeout", 32'(ok), 1);
    endtask

    task automatic drain();
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (sb.size() == 0 && !out_valid) begin
                ok = 1'b1;
                break;
            end
        end
        checkOutput("drain_timeout", 32'(ok), 1);
        @(posedge clk);
        #1;
    endtask

    initial begin
        bit seen;
        rst_n = 1'b0;
        in_valid = 1'b0;
        in_code = '0;
        out_ready = 1'b1;
        cnt_clr = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("rst_out_valid", 32'(out_valid), 0);
        checkOutput("rst_out_data", 32'(out_data), 0);
        checkOutput("rst_out_syndrome", 32'(out_syndrome), 0);
        checkOutput("rst_out_err_type", 32'(out_err_type), 0);
        checkOutput("rst_cnt_corr", 32'(cnt_corr), 0);
        checkOutput("rst_cnt_uncorr", 32'(cnt_uncorr), 0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Clean word and two-cycle latency
        applyStimulus(13'h0A27, 8'hA5, 4'd0, 2'b00);
        checkOutput("latency_early", 32'(out_valid), 0);
        @(posedge clk);
        #1 checkOutput("latency_out", 32'(out_valid), 1);
        drain();
        checkOutput("clean_cnt_corr", 32'(cnt_corr), 0);

        applyStimulus(13'h0A07, 8'hA5, 4'd6, 2'b10);
        drain();
        checkOutput("single_cnt_corr", 32'(cnt_corr), 1);
        applyStimulus(13'h1A27, 8'hA5, 4'd0, 2'b01);
        drain();
        checkOutput("wpar_cnt_corr", 32'(cnt_corr), 2);
        applyStimulus(13'h0A06, 8'hA1, 4'd7, 2'b11);
        drain();
        checkOutput("double_cnt_uncorr", 32'(cnt_uncorr), 1);
        applyStimulus(13'h0AAE, 8'hA5, 4'd13, 2'b11);
        drain();
        checkOutput("triple_cnt_uncorr", 32'(cnt_uncorr), 2);

        // Backpressure: two words fill the pipe, the third is refused until out_ready returns
        out_ready = 1'b0;
        applyStimulus(encode(8'h3C), 8'h3C, 4'd0, 2'b00);
        applyStimulus(encode(8'hC3), 8'hC3, 4'd0, 2'b00);
        pend = '{data: 8'h5A, syn: 4'd0, et: 2'b00};
        in_code = encode(8'h5A);
        in_valid = 1'b1;
        @(negedge clk);
        checkOutput("stall_in_ready", 32'(in_ready), 0);
        checkOutput("stall_out_data", 32'(out_data), 32'h3C);
        @(posedge clk);
        #1 out_ready = 1'b1;
        applyStimulus(encode(8'h5A), 8'h5A, 4'd0, 2'b00);
        applyStimulus(encode(8'h0F), 8'h0F, 4'd0, 2'b00);
        drain();

        // Saturation at 3 after a clear
        cnt_clr = 1'b1;
        @(posedge clk);
        #1 cnt_clr = 1'b0;
        checkOutput("clr_cnt_corr", 32'(cnt_corr), 0);
        checkOutput("clr_cnt_uncorr", 32'(cnt_uncorr), 0);
        applyStimulus(flip(encode(8'h12), 1), 8'h12, 4'd1, 2'b10);
        applyStimulus(flip(encode(8'h34), 4), 8'h34, 4'd4, 2'b10);
        applyStimulus(flip(encode(8'h56), 5), 8'h56, 4'd5, 2'b10);
        applyStimulus(flip(encode(8'h78), 9), 8'h78, 4'd9, 2'b10);
        applyStimulus(flip(encode(8'h9A), 12), 8'h9A, 4'd12, 2'b10);
        drain();
        checkOutput("sat_cnt_corr", 32'(cnt_corr), 3);

        // Clear in the same cycle as a corrected result transfers
        out_ready = 1'b0;
        applyStimulus(flip(encode(8'h77), 6), 8'h77, 4'd6, 2'b10);
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            #1;
            if (out_valid) begin
                seen = 1'b1;
                break;
            end
        end
        checkOutput("clr_wait_valid", 32'(seen), 1);
        out_ready = 1'b1;
        cnt_clr = 1'b1;
        @(posedge clk);
        #1 cnt_clr = 1'b0;
        checkOutput("clr_wins", 32'(cnt_corr), 0);
        drain();

        // Reset with two words in flight
        out_ready = 1'b0;
        applyStimulus(encode(8'h11), 8'h11, 4'd0, 2'b00);
        applyStimulus(encode(8'h22), 8'h22, 4'd0, 2'b00);
        checkOutput("pre_rst_valid", 32'(out_valid), 1);
        rst_n = 1'b0;
        #1;
        checkOutput("midrst_out_valid", 32'(out_valid), 0);
        checkOutput("midrst_out_data", 32'(out_data), 0);
        checkOutput("midrst_cnt_corr", 32'(cnt_corr), 0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        out_ready = 1'b1;
        repeat (5) @(posedge clk);
        #1 checkOutput("post_rst_no_output", 32'(out_valid), 0);
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
